// File: rtl/gain_pkg.sv
// gain_pkg: shared definitions for the gain ramp controller.
//   - Avalon-MM word addresses of the register map
//   - FSM state encoding
//   - unity_coef(): value of 1.0 in the ufi(w, w/2) coefficient format
package gain_pkg;

  localparam logic [1:0] ADDR_TARGET = 2'd0;
  localparam logic [1:0] ADDR_STEP   = 2'd1;
  localparam logic [1:0] ADDR_PERIOD = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    STEP = 2'd2
  } state_t;

  // Unity gain has the single integer LSB set: 2**(w/2).
  function automatic logic [31:0] unity_coef(input int w);
    return 32'd1 << (w / 2);
  endfunction

endpackage

// File: rtl/gain_ramp_step.sv
// gain_ramp_step: combinational next-coefficient computation.
// Moves coef one STEP toward target and clamps to target when the move
// would overshoot (upward) or pass below target / underflow (downward).
// Ports:
//   coef      current coefficient
//   target    coefficient being ramped toward
//   step      step size
//   next_coef coefficient after one step
module gain_ramp_step #(
  parameter int W = 16
) (
  input  logic [W-1:0] coef,
  input  logic [W-1:0] target,
  input  logic [W-1:0] step,
  output logic [W-1:0] next_coef
);

  // One extra bit catches carry-out on the way up and borrow on the way down.
  logic [W:0] sum;
  logic [W:0] diff;

  always_comb begin
    sum  = {1'b0, coef} + {1'b0, step};
    diff = {1'b0, coef} - {1'b0, step};
    next_coef = target;
    if (coef < target) begin
      if (sum <= {1'b0, target}) next_coef = sum[W-1:0];
    end else if (coef > target) begin
      if (!diff[W] && (diff[W-1:0] >= target)) next_coef = diff[W-1:0];
    end
  end

endmodule

// File: rtl/gain_ramp_ctrl.sv
// gain_ramp_ctrl: Avalon-MM controlled gain coefficient ramp.
// The coefficient walks toward TARGET by STEP once every PERIOD+1 sample
// strobes. Register map (word addresses): 0 TARGET, 1 STEP, 2 PERIOD,
// 3 STATUS (read {30'b0, irqPend, busy}; write bit1 = abort, bit0 = irq clear).
// Optional feature: define GAIN_RAMP_IRQ_EN to add the level interrupt irq.
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   avsAddr/avsWr/avsWrData/avsRdData  register interface, 1-cycle read latency
//   sampleStrb   one pulse per audio sample, paces the ramp
//   coef         gain coefficient, ufi(COEF_WDT, COEF_WDT/2)
//   busy         ramp in progress
//   done         one-cycle pulse when coef reaches target
//   irq          (GAIN_RAMP_IRQ_EN only) pending-interrupt level
//   dbgState     current FSM state encoding
//
// Handshake: the register port has no wait states; a write is accepted on
// every cycle avsWr is high, and avsRdData always holds the register
// selected by avsAddr on the previous cycle.
module gain_ramp_ctrl
  import gain_pkg::*;
#(
  parameter int COEF_WDT = 16,
  parameter int PER_WDT  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          avsAddr,
  input  logic                avsWr,
  input  logic [31:0]         avsWrData,
  output logic [31:0]         avsRdData,
  input  logic                sampleStrb,
  output logic [COEF_WDT-1:0] coef,
  output logic                busy,
  output logic                done,
`ifdef GAIN_RAMP_IRQ_EN
  output logic                irq,
`endif
  output logic [1:0]          dbgState
);

  localparam logic [COEF_WDT-1:0] UNITY = COEF_WDT'(unity_coef(COEF_WDT));

  state_t              state, state_nxt;
  logic [COEF_WDT-1:0] coef_r, coef_nxt;
  logic [COEF_WDT-1:0] target_r, step_r;
  logic [PER_WDT-1:0]  period_r, cnt_r, cnt_nxt;
  logic                done_r, done_nxt;
  logic [31:0]         rd_r, rd_nxt;
  logic                irq_pend;

  logic                wr_target, wr_step, wr_period, wr_status;
  logic                abort;
  logic                hi_set;
  logic [COEF_WDT-1:0] wr_sat;
  logic [COEF_WDT-1:0] step_target;
  logic [COEF_WDT-1:0] next_coef;

  // Write decode and saturation of TARGET/STEP data to the field width.
  always_comb begin
    wr_target = avsWr && (avsAddr == ADDR_TARGET);
    wr_step   = avsWr && (avsAddr == ADDR_STEP);
    wr_period = avsWr && (avsAddr == ADDR_PERIOD);
    wr_status = avsWr && (avsAddr == ADDR_STATUS);
    abort     = wr_status && avsWrData[1];
    hi_set    = (COEF_WDT < 32) ? ((avsWrData >> COEF_WDT) != 32'd0) : 1'b0;
    wr_sat    = hi_set ? {COEF_WDT{1'b1}} : avsWrData[COEF_WDT-1:0];
    // A TARGET write landing on the step cycle steers that step already,
    // so the done decision is made against the target software just set.
    step_target = wr_target ? wr_sat : target_r;
  end

  gain_ramp_step #(
    .W(COEF_WDT)
  ) u_step (
    .coef      (coef_r),
    .target    (step_target),
    .step      (step_r),
    .next_coef (next_coef)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM next-state and datapath next-values.
  always_comb begin
    state_nxt = state;
    coef_nxt  = coef_r;
    cnt_nxt   = cnt_r;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (wr_target) begin
          if (step_r == '0) begin
            // Zero step means jump straight to the new target.
            coef_nxt = wr_sat;
            done_nxt = 1'b1;
          end else if (wr_sat != coef_r) begin
            state_nxt = WAIT;
            cnt_nxt   = period_r;
          end
        end
      end
      WAIT: begin
        if (sampleStrb) begin
          if (cnt_r == '0) state_nxt = STEP;
          else             cnt_nxt   = cnt_r - 1'b1;
        end
      end
      STEP: begin
        coef_nxt = next_coef;
        if (next_coef == step_target) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end else begin
          state_nxt = WAIT;
          cnt_nxt   = period_r;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Abort only means something while a ramp is running; TARGET cannot be
    // written in the same cycle, so target_r is the final value.
    if (abort && (state != IDLE)) begin
      state_nxt = IDLE;
      coef_nxt  = target_r;
      done_nxt  = 1'b1;
    end
  end

  // Read mux, registered below for the 1-cycle latency.
  always_comb begin
    rd_nxt = 32'd0;
    case (avsAddr)
      ADDR_TARGET: rd_nxt = 32'(target_r);
      ADDR_STEP:   rd_nxt = 32'(step_r);
      ADDR_PERIOD: rd_nxt = 32'(period_r);
      ADDR_STATUS: rd_nxt = {30'd0, irq_pend, (state != IDLE)};
      default:     rd_nxt = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      coef_r   <= UNITY;
      target_r <= UNITY;
      step_r   <= COEF_WDT'(1);
      period_r <= '0;
      cnt_r    <= '0;
      done_r   <= 1'b0;
      rd_r     <= 32'd0;
    end else begin
      coef_r <= coef_nxt;
      cnt_r  <= cnt_nxt;
      done_r <= done_nxt;
      rd_r   <= rd_nxt;
      if (wr_target) target_r <= wr_sat;
      if (wr_step)   step_r   <= wr_sat;
      if (wr_period) period_r <= avsWrData[PER_WDT-1:0];
    end
  end

`ifdef GAIN_RAMP_IRQ_EN
  // Set on the same edge done rises so irq and done go high together;
  // a clear arriving on that edge loses to the set.
  always_ff @(posedge clk) begin
    if (reset)                           irq_pend <= 1'b0;
    else if (done_nxt)                   irq_pend <= 1'b1;
    else if (wr_status && avsWrData[0])  irq_pend <= 1'b0;
  end
  assign irq = irq_pend;
`else
  assign irq_pend = 1'b0;
`endif

  assign coef      = coef_r;
  assign done      = done_r;
  assign busy      = (state != IDLE);
  assign avsRdData = rd_r;
  assign dbgState  = state;

endmodule
